// File: rtl/rc5_req_arbiter.sv
// Two-client round-robin front end for a single rc5_core: latches the granted request,
// reloads the core key only when it changes, and guards each core handshake with a watchdog.
module rc5_req_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [127:0] key_a,
  input  logic [127:0] key_b,
  input  logic [63:0]  din_a,
  input  logic [63:0]  din_b,
  input  logic         flag_a,
  input  logic         flag_b,
  output logic         ack_a,
  output logic         ack_b,
  output logic [63:0]  res,
  output logic         err,
  output logic         busy,
  output logic         core_flag,
  output logic [127:0] core_key,
  output logic         core_key_en,
  input  logic         core_key_ok,
  output logic [63:0]  core_din,
  output logic         core_din_en,
  input  logic [63:0]  core_dout,
  input  logic         core_dout_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_LOAD, S_KEY_WAIT, S_DATA_ISSUE, S_DATA_WAIT, S_RESP
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic   [127:0] r_key;
  logic   [63:0]  r_din;
  logic           r_flag;
  logic           r_owner_b;
  logic           r_rr_ptr;
  logic   [127:0] r_loaded_key;
  logic           r_key_valid;
  logic   [15:0]  r_wdog;
  logic   [63:0]  r_res;
  logic           r_err;

  logic           w_grant_valid;
  logic           w_grant_b;
  logic   [127:0] w_sel_key;
  logic           w_wdog_expired;

  // With both requests high, r_rr_ptr (0 = A, 1 = B) decides.
  assign w_grant_valid  = req_a | req_b;
  assign w_grant_b      = req_b & (~req_a | r_rr_ptr);
  assign w_sel_key      = w_grant_b ? key_b : key_a;
  assign w_wdog_expired = (r_wdog == 16'(TIMEOUT - 1));

  // NOTE: every signal driven in always_comb gets a default first, otherwise a path
  // that forgets to assign it infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          if (!r_key_valid || (w_sel_key != r_loaded_key)) w_next = S_KEY_LOAD;
          else                                             w_next = S_DATA_ISSUE;
        end
      end
      S_KEY_LOAD:   w_next = S_KEY_WAIT;
      S_KEY_WAIT: begin
        if (core_key_ok)         w_next = S_DATA_ISSUE;
        else if (w_wdog_expired) w_next = S_RESP;
      end
      S_DATA_ISSUE: w_next = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (core_dout_en || w_wdog_expired) w_next = S_RESP;
      end
      S_RESP:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_din        <= '0;
      r_flag       <= 1'b0;
      r_owner_b    <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_loaded_key <= '0;
      r_key_valid  <= 1'b0;
      r_wdog       <= '0;
      r_res        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE && w_grant_valid) begin
        r_key     <= w_sel_key;
        r_din     <= w_grant_b ? din_b  : din_a;
        r_flag    <= w_grant_b ? flag_b : flag_a;
        r_owner_b <= w_grant_b;
        r_rr_ptr  <= ~w_grant_b;
      end

      if (r_state == S_KEY_LOAD || r_state == S_DATA_ISSUE) r_wdog <= '0;
      else if (r_state == S_KEY_WAIT || r_state == S_DATA_WAIT) r_wdog <= r_wdog + 16'd1;

      // A handshake arriving on the expiry cycle wins over the abort.
      if (r_state == S_KEY_WAIT) begin
        if (core_key_ok) begin
          r_loaded_key <= r_key;
          r_key_valid  <= 1'b1;
        end else if (w_wdog_expired) begin
          r_key_valid <= 1'b0;
          r_res       <= '0;
          r_err       <= 1'b1;
        end
      end

      if (r_state == S_DATA_WAIT) begin
        if (core_dout_en) begin
          r_res <= core_dout;
          r_err <= 1'b0;
        end else if (w_wdog_expired) begin
          r_key_valid <= 1'b0;
          r_res       <= '0;
          r_err       <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign core_key_en = (r_state == S_KEY_LOAD);
  assign core_din_en = (r_state == S_DATA_ISSUE);
  assign core_key    = r_key;
  assign core_din    = r_din;
  assign core_flag   = r_flag;
  assign ack_a       = (r_state == S_RESP) & ~r_owner_b;
  assign ack_b       = (r_state == S_RESP) &  r_owner_b;
  assign res         = (r_state == S_RESP) ? r_res : 64'd0;
  assign err         = (r_state == S_RESP) & r_err;

endmodule

// File: tb/tb_rc5_req_arbiter.sv
// Directed bench for rc5_req_arbiter with a behavioural core (key latency K, data latency L,
// result = ~din) and hand-computed ack latencies, results and key-load counts.
module tb_rc5_req_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [127:0] key_a = '0, key_b = '0;
  logic [63:0]  din_a = '0, din_b = '0;
  logic         flag_a = 1'b0, flag_b = 1'b0;
  logic         ack_a, ack_b, err, busy, core_flag, core_key_en, core_din_en;
  logic [63:0]  res, core_din;
  logic [127:0] core_key;
  logic         core_key_ok, core_dout_en;
  logic [63:0]  core_dout;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  localparam int K = 3;
  localparam int L = 5;
  localparam logic [127:0] KA = 128'h0;
  localparam logic [127:0] KB = 128'h0123456789abcdef_fedcba9876543210;

  logic        m_key_ok, m_dout_en, m_no_dout = 1'b0;
  logic [63:0] m_dout;
  int          kcnt, dcnt;
  logic        sp_key_ok = 1'b0, sp_dout_en = 1'b0;

  always #5 clk = ~clk;

  rc5_req_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .key_a(key_a), .key_b(key_b),
    .din_a(din_a), .din_b(din_b), .flag_a(flag_a), .flag_b(flag_b),
    .ack_a(ack_a), .ack_b(ack_b), .res(res), .err(err), .busy(busy),
    .core_flag(core_flag), .core_key(core_key), .core_key_en(core_key_en),
    .core_key_ok(core_key_ok), .core_din(core_din), .core_din_en(core_din_en),
    .core_dout(core_dout), .core_dout_en(core_dout_en)
  );

  // Core model: key_ok K cycles after key_en, dout_en L cycles after din_en.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_key_ok <= 1'b0; m_dout_en <= 1'b0; m_dout <= '0; kcnt <= 0; dcnt <= 0;
    end else begin
      m_key_ok  <= 1'b0;
      m_dout_en <= 1'b0;
      if (core_key_en) begin
        if (K == 1) m_key_ok <= 1'b1; else kcnt <= K - 1;
      end else if (kcnt != 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) m_key_ok <= 1'b1;
      end
      if (core_din_en) begin
        m_dout <= ~core_din;
        if (L == 1) m_dout_en <= !m_no_dout; else dcnt <= L - 1;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) m_dout_en <= !m_no_dout;
      end
    end
  end

  assign core_key_ok  = m_key_ok | sp_key_ok;
  assign core_dout_en = m_dout_en | sp_dout_en;
  assign core_dout    = m_dout;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          w_n, w_keys, w_dins;
  logic        w_ack_a, w_ack_b, w_err, w_flag;
  logic [63:0] w_res;

  // Returns w_n = number of negedges after the grant edge until an ack (0 if none in 64).
  task automatic wait_ack();
    w_n = 0; w_keys = 0; w_dins = 0; w_ack_a = 0; w_ack_b = 0; w_err = 0; w_res = '0; w_flag = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (core_key_en) w_keys++;
      if (core_din_en) begin w_dins++; w_flag = core_flag; end
      if (core_key_en && core_din_en) overlap++;
      if (ack_a || ack_b) begin
        w_n = i; w_ack_a = ack_a; w_ack_b = ack_b; w_res = res; w_err = err;
        break;
      end
    end
  endtask

  task automatic issue_a(input logic [127:0] k, input logic [63:0] d, input logic f);
    @(negedge clk);
    req_a = 1'b1; key_a = k; din_a = d; flag_a = f;
  endtask

  task automatic check_txn(input string tag, input bit side_b, input int n, input int keys,
                           input logic [63:0] r, input logic e);
    check({tag, "_lat"},  w_n, n);
    check({tag, "_ack"},  {w_ack_a, w_ack_b}, side_b ? 2'b01 : 2'b10);
    check({tag, "_keys"}, w_keys, keys);
    check({tag, "_dins"}, w_dins, 1);
    check({tag, "_res"},  w_res, r);
    check({tag, "_err"},  w_err, e);
  endtask

  initial begin
    int bad;
    // Reset state
    @(negedge clk);
    check("rst_ctl", {ack_a, ack_b, busy, err, core_key_en, core_din_en, core_flag}, 7'd0);
    check("rst_res", res, 64'd0);
    check("rst_key", core_key, 128'd0);
    check("rst_din", core_din, 64'd0);
    rst = 1'b1;

    // Single A, key 0 on a never-loaded core: key miss, T+K+L+3 = 11
    issue_a(KA, 64'h0123456789ABCDEF, 1'b1);
    wait_ack();
    check_txn("a1", 0, 11, 1, 64'hFEDCBA9876543210, 1'b0);
    check("a1_flag", w_flag, 1'b1);
    req_a = 1'b0;

    // Same key again: hit, T+L+2 = 7
    issue_a(KA, 64'h0000_0000_FFFF_0000, 1'b0);
    wait_ack();
    check_txn("a2", 0, 7, 0, 64'hFFFF_FFFF_0000_FFFF, 1'b0);
    check("a2_flag", w_flag, 1'b0);
    req_a = 1'b0;
    @(negedge clk);
    check("idle_out", {busy, err, res}, 66'd0);

    // Simultaneous pair after reset: A first, then B (reload), then A again with B still pending
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    req_a = 1'b1; key_a = KA; din_a = 64'h1111_2222_3333_4444; flag_a = 1'b0;
    req_b = 1'b1; key_b = KB; din_b = 64'hA5A5_A5A5_5A5A_5A5A; flag_b = 1'b1;
    wait_ack();
    check_txn("pa", 0, 11, 1, 64'hEEEE_DDDD_CCCC_BBBB, 1'b0);
    din_a = 64'h0F0F_0F0F_0F0F_0F0F;
    wait_ack();
    check_txn("pb", 1, 12, 1, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0);
    check("pb_flag", w_flag, 1'b1);
    req_b = 1'b0;
    wait_ack();
    check_txn("pa2", 0, 12, 1, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
    req_a = 1'b0;

    // Watchdog: core never answers; 8 DATA_WAIT cycles then RESP at n=10
    m_no_dout = 1'b1;
    issue_a(KA, 64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_ack();
    check_txn("to", 0, 10, 0, 64'd0, 1'b1);
    req_a = 1'b0;
    m_no_dout = 1'b0;
    issue_a(KA, 64'hDEAD_BEEF_0000_0001, 1'b0);
    wait_ack();
    check_txn("to_rel", 0, 11, 1, 64'h2152_4110_FFFF_FFFE, 1'b0);
    req_a = 1'b0;

    // Asynchronous reset during DATA_WAIT
    issue_a(KA, 64'h5555_5555_5555_5555, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", {ack_a, ack_b, busy, err, core_key_en, core_din_en, core_flag}, 7'd0);
    check("mid_rst_data", {res, core_din}, 128'd0);
    check("mid_rst_key", core_key, 128'd0);
    @(negedge clk);
    check("mid_rst_hold", {ack_a, ack_b, busy}, 3'd0);
    rst = 1'b1; req_a = 1'b0;
    issue_a(KA, 64'h8000_0000_0000_0000, 1'b0);
    wait_ack();
    check_txn("post_rst", 0, 11, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    req_a = 1'b0;

    // Spurious handshakes while idle
    bad = 0;
    @(negedge clk); sp_key_ok = 1'b1;
    @(negedge clk); sp_key_ok = 1'b0; sp_dout_en = 1'b1;
    if (busy || ack_a || ack_b) bad++;
    @(negedge clk); sp_dout_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (busy || ack_a || ack_b || err) bad++;
      @(negedge clk);
    end
    check("spurious", bad, 0);
    issue_a(KA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_ack();
    check_txn("after_sp", 0, 7, 0, 64'd0, 1'b0);
    req_a = 1'b0;

    check("en_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
